dmem_port_ctrl: RTL
===================

# dmem_port_ctrl

Data-memory port controller for the MEM stage of the 5-stage pipeline. It takes one load/store request from the pipeline, converts it to a word-aligned single-request transaction on the data port (port B) of the dual-port memory, and holds the pipeline stalled until the access completes. It also generates byte-lane write masks, replicates store data across lanes, and aligns and sign- or zero-extends load data.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: cycles waited in REQ for `mem_resp` before aborting. Used only with DMEM_TIMEOUT_EN. Range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage holds a memory op. Held stable with its operands while `stall`=1.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I width code. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- stall  out  1  combinational: `req_valid & ~done`.
- done  out  1  registered; 1 for exactly one cycle when the op completes.
- load_data  out  32  aligned, extended load result. Valid while `done`=1; otherwise holds its last value.
- err  out  1  registered; pulses together with `done` on a fault.
- mem_read  out  1  registered; to the memory's `read_b`.
- mem_write  out  1  registered; to the memory's `write`.
- mem_wmask  out  4  registered byte-lane enables.
- mem_address  out  32  registered; always `{req_addr[31:2],2'b00}`.
- mem_wdata  out  32  registered lane-replicated store data.
- mem_resp  in  1  from the memory's `resp_b`.
- mem_rdata  in  32  from the memory's `rdata_b`.

## Operation
- Reset values: every registered output is 0, and the state is IDLE.
- States:
  - IDLE: sample the request.
  - REQ: drive the memory request and wait for `mem_resp`.
  - DRAIN: one cycle with `done`=1.
- IDLE, `req_valid`=1, legal op → REQ. In the same edge, load `mem_read`=~`req_we`, `mem_write`=`req_we`, address, mask and wdata.
- IDLE, `req_valid`=1, illegal op → DRAIN with `err`=1. No memory request is issued. Illegal ops are:
  - misaligned: halfword with `addr[0]`=1; word with `addr[1:0]`≠0.
  - undefined funct3: loads 3/6/7; stores ≥3.
- REQ, `mem_resp`=1 → DRAIN.
  - Clear `mem_read`/`mem_write`.
  - Set `done`.
  - For loads, register `load_data`.
- DRAIN → IDLE unconditionally. `done`/`err` clear. `mem_resp` is ignored in DRAIN; it is still 1 here because the memory saw `mem_read`=1 on the previous edge.
- `mem_resp` is ignored in every state except REQ.
- Write mask:
  - SB: `4'b0001 << addr[1:0]`
  - SH: `4'b0011 << addr[1:0]`
  - SW: `4'b1111`
  - Loads drive 0.
- Store data:
  - SB: `{4{wdata[7:0]}}`
  - SH: `{2{wdata[15:0]}}`
  - SW: unchanged.
- Load data:
  - Shift `mem_rdata` right by `8*addr[1:0]`.
  - Sign-extend from bit 7 (LB) or bit 15 (LH).
  - Zero-extend for LBU/LHU.
  - Pass LW through.
- Store writes may land in memory on more than one cycle while `mem_write` is held. This is harmless because the data is the same.

## Timing
- Legal access, with request first visible in cycle 0:
  - cycle 1: `mem_read`/`mem_write`=1.
  - cycle 2: `mem_resp`=1.
  - cycle 3: `done`=1, `stall`=0.
  - Earliest next request is sampled in IDLE at cycle 4.
- Stall is therefore 3 cycles for a zero-wait memory.
- Fault: `done`=`err`=1 in cycle 1; the next request is sampled in cycle 2.
- In the DRAIN cycle `req_valid` may already belong to the next instruction. It is not sampled until IDLE.
- Reset asserted mid-operation:
  - All registered outputs clear immediately.
  - The state goes to IDLE and the op is dropped.
  - A stale `mem_resp` is ignored.
  - After reset release, a still-asserted `req_valid` is re-issued from IDLE.

## Configuration
- DMEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle with `mem_resp`=0.
  - When the count reaches TIMEOUT_CYCLES with `mem_resp`=0: deassert the request, go to DRAIN with `done`=`err`=1, and leave `load_data` unchanged.
- DMEM_TIMEOUT_EN undefined: no counter. REQ waits indefinitely and `err` comes only from illegal ops.

## Test plan
- LW 0x100, memory word 0xDEADBEEF → `mem_read`=1 and `mem_address`=0x100 in cycle 1; `done`=1 and `load_data`=0xDEADBEEF in cycle 3; `stall`=1 in cycles 0–2; `err`=0.
- LB 0x103 with word 0x80AA55CC → `load_data`=0xFFFFFF80. LBU same address → 0x00000080. LH 0x102 → 0xFFFF80AA.
- SH 0x102 with `req_wdata`=0x1234ABCD → `mem_wmask`=4'b1100 and `mem_wdata`=0xABCDABCD. A following LW 0x100 over prior word 0 returns 0xABCD0000.
- LW 0x101 → `mem_read` never asserts; `done`=`err`=1 in cycle 1; `stall` low in cycle 1. LB with funct3=3 → same behaviour.
- `rst_n` pulsed low in cycle 2 of an LW → `mem_read`=0 and `done`=0 immediately. With `req_valid` still high after release, the access restarts and completes 4 cycles after release with correct data.
- DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, `mem_resp` tied 0, SW issued → `mem_write` high for 9 cycles (cycles 1–9); `done`=`err`=1 in cycle 10; `mem_write`=0 from cycle 10.

Source files
------------

// File: rtl/dmem_port_ctrl_if.sv
// Pipeline-side request/response and memory port B signals of dmem_port_ctrl.
// slave: the controller's view; master: the pipeline plus memory environment.
interface dmem_port_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        err;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_resp, mem_rdata,
    output stall, done, load_data, err, mem_read, mem_write, mem_wmask, mem_address, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_resp, mem_rdata,
    input  stall, done, load_data, err, mem_read, mem_write, mem_wmask, mem_address, mem_wdata
  );
endinterface

// File: rtl/dmem_port_ctrl.sv
// MEM-stage data-memory port controller: one load/store per request, lane masks, load alignment.
// Optional REQ timeout abort is enabled by defining DMEM_TIMEOUT_EN.
module dmem_port_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic             clk,
  input logic             rst_n,
  dmem_port_ctrl_if.slave bus
);

  if ((TIMEOUT_CYCLES == 0) || (TIMEOUT_CYCLES > 255)) begin : g_param_chk
    $error("dmem_port_ctrl: TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t      state, state_nxt;
  logic        done_q, done_nxt;
  logic        err_q, err_nxt;
  logic        read_q, read_nxt;
  logic        write_q, write_nxt;
  logic [3:0]  wmask_q, wmask_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic [31:0] ldata_q, ldata_nxt;
`ifdef DMEM_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_nxt;
`endif

  logic [1:0]  off_c;
  logic        legal_c;
  logic        fn_ok_c;
  logic        align_ok_c;
  logic [3:0]  mask_c;
  logic [31:0] repl_c;
  logic [31:0] shifted_c;
  logic [31:0] ext_c;

  assign off_c     = bus.req_addr[1:0];
  assign shifted_c = bus.mem_rdata >> {off_c, 3'b000};

  // Request decode: legality, byte-lane mask, replicated store data, load extension
  always_comb begin
    fn_ok_c    = bus.req_we ? (bus.req_funct3 < 3'd3)
                            : ((bus.req_funct3 != 3'd3) && (bus.req_funct3 < 3'd6));
    align_ok_c = 1'b1;
    mask_c     = 4'b0000;
    repl_c     = bus.req_wdata;
    ext_c      = shifted_c;
    case (bus.req_funct3[1:0])
      2'd0: begin
        mask_c = 4'b0001 << off_c;
        repl_c = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        align_ok_c = ~off_c[0];
        mask_c     = 4'b0011 << off_c;
        repl_c     = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        align_ok_c = (off_c == 2'd0);
        mask_c     = 4'b1111;
      end
    endcase
    if (!bus.req_we) mask_c = 4'b0000;
    legal_c = fn_ok_c & align_ok_c;
    case (bus.req_funct3)
      3'd0:    ext_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'd1:    ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'd4:    ext_c = {24'd0, shifted_c[7:0]};
      3'd5:    ext_c = {16'd0, shifted_c[15:0]};
      default: ext_c = shifted_c;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    read_nxt  = read_q;
    write_nxt = write_q;
    wmask_nxt = wmask_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    ldata_nxt = ldata_q;
`ifdef DMEM_TIMEOUT_EN
    cnt_nxt   = cnt_q;
`endif
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (legal_c) begin
            state_nxt = REQ;
            read_nxt  = ~bus.req_we;
            write_nxt = bus.req_we;
            wmask_nxt = mask_c;
            addr_nxt  = {bus.req_addr[31:2], 2'b00};
            wdata_nxt = repl_c;
`ifdef DMEM_TIMEOUT_EN
            cnt_nxt   = 8'd0;
`endif
          end else begin
            state_nxt = DRAIN;
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus.mem_resp) begin
          state_nxt = DRAIN;
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
          done_nxt  = 1'b1;
          if (!bus.req_we) ldata_nxt = ext_c;
`ifdef DMEM_TIMEOUT_EN
        end else if (cnt_q == 8'(TIMEOUT_CYCLES)) begin
          state_nxt = DRAIN;
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_q + 8'd1;
`endif
        end
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      wmask_q <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ldata_q <= 32'd0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state   <= state_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      read_q  <= read_nxt;
      write_q <= write_nxt;
      wmask_q <= wmask_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      ldata_q <= ldata_nxt;
`ifdef DMEM_TIMEOUT_EN
      cnt_q   <= cnt_nxt;
`endif
    end
  end

  assign bus.stall       = bus.req_valid & ~done_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.load_data   = ldata_q;
  assign bus.mem_read    = read_q;
  assign bus.mem_write   = write_q;
  assign bus.mem_wmask   = wmask_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;

endmodule
